// File: rtl/seg_disp_arbiter.sv
// Round-robin scheduler sharing one hex8_2 display between four sources (SEG_PREEMPT_EN: source 0 preempts).
// Latency: one cycle from request/data sample to registered grant and display outputs.
// Backpressure: a granted source holds the display for DWELL_CYC cycles unless it drops its request.
module seg_disp_arbiter #(
    parameter int unsigned DWELL_CYC = 50_000_000,
    parameter logic [31:0] IDLE_DATA = 32'h0000_0000,
    parameter logic [2:0]  IDLE_MODE = 3'd0
) (
    input  logic         Clk,
    input  logic         Reset_N,
    input  logic [3:0]   Src_Req,
    input  logic [127:0] Src_Data,
    input  logic [11:0]  Src_Mode,
    output logic [3:0]   Src_Grant,
    output logic [31:0]  Disp_Data,
    output logic [2:0]   state,
    output logic         Busy
);

    localparam int unsigned CW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DWELL_CYC - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    logic [0:0]    fsm_q,   fsm_d;
    logic [3:0]    grant_q, grant_d;
    logic [1:0]    last_q,  last_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [31:0]   disp_q,  disp_d;
    logic [2:0]    mode_q,  mode_d;

    logic [3:0] others;
    logic [1:0] rr_idx;
    logic [1:0] pick_idx;
    logic [1:0] show_idx;
    logic       new_grant;
    logic       preempt;

    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && req[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

`ifdef SEG_PREEMPT_EN
    logic req0_q;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            req0_q <= 1'b0;
        end else begin
            req0_q <= Src_Req[0];
        end
    end

    // Only a rising request preempts, so source 0 cannot starve the others by holding its request.
    assign preempt = (fsm_q == ST_SHOW) && Src_Req[0] && !req0_q && !grant_q[0];
`else
    assign preempt = 1'b0;
`endif

    // In SHOW grant_q is one-hot on last_q, so masking it leaves only the competing requesters.
    assign others = Src_Req & ~grant_q;
    assign rr_idx = rr_pick(others, last_q + 2'd1);

    always_comb begin
        fsm_d     = fsm_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        new_grant = 1'b0;
        pick_idx  = rr_idx;
        case (fsm_q)
            ST_IDLE: begin
                if (|others) begin
                    new_grant = 1'b1;
                end
            end
            default: begin
                if (preempt) begin
                    new_grant = 1'b1;
                    pick_idx  = 2'd0;
                end else if (!(|(Src_Req & grant_q))) begin
                    if (|others) begin
                        new_grant = 1'b1;
                    end else begin
                        fsm_d   = ST_IDLE;
                        grant_d = 4'b0000;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    if (|others) begin
                        new_grant = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
        if (new_grant) begin
            fsm_d   = ST_SHOW;
            grant_d = 4'b0001 << pick_idx;
            last_d  = pick_idx;
            cnt_d   = '0;
        end
    end

    // Display registers follow the next grant so the new source's word appears with its grant.
    assign show_idx = new_grant ? pick_idx : last_q;

    always_comb begin
        disp_d = IDLE_DATA;
        mode_d = IDLE_MODE;
        if (fsm_d == ST_SHOW) begin
            disp_d = Src_Data[32*show_idx +: 32];
            mode_d = Src_Mode[3*show_idx +: 3];
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            fsm_q   <= ST_IDLE;
            grant_q <= 4'b0000;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            disp_q  <= IDLE_DATA;
            mode_q  <= IDLE_MODE;
        end else begin
            fsm_q   <= fsm_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            mode_q  <= mode_d;
        end
    end

    assign Src_Grant = grant_q;
    assign Disp_Data = disp_q;
    assign state     = mode_q;
    assign Busy      = |grant_q;

endmodule

// File: doc/seg_disp_arbiter.md
# seg_disp_arbiter

Round-robin display scheduler that shares one `hex8_2` 8-digit seven-segment driver between four requesting sources. Each source presents a 32-bit digit word and a 3-bit display mode. The arbiter grants one source at a time, holds it for a minimum dwell period, and drives the registered `Disp_Data`/`state` pair into `hex8_2`. It sits directly upstream of `hex8_2` in the display subsystem.

## Interface
- `DWELL_CYC`, 50_000_000 — minimum cycles a granted source is shown before another pending source may take over; legal range ≥2.
- `IDLE_DATA`, 32'h0000_0000 — `Disp_Data` value while no source is granted.
- `IDLE_MODE`, 3'd0 — `state` value while no source is granted.
- `Clk`  in  1  system clock; all logic on the rising edge.
- `Reset_N`  in  1  asynchronous, active-low reset.
- `Src_Req`  in  4  request per source; bit i = source i.
- `Src_Data`  in  128  digit words; source i on `[32*i+31:32*i]`.
- `Src_Mode`  in  12  mode words; source i on `[3*i+2:3*i]`.
- `Src_Grant`  out  4  one-hot grant, or all-zero when idle.
- `Disp_Data`  out  32  word for `hex8_2.Disp_Data`.
- `state`  out  3  mode for `hex8_2.state`.
- `Busy`  out  1  high whenever `Src_Grant != 0`.

## Operation
- FSM has two states:
  - IDLE: no grant; outputs `IDLE_DATA`/`IDLE_MODE`.
  - SHOW: one source granted.
- IDLE → SHOW: when any `Src_Req` bit is high, grant the first requester found searching round-robin from `last+1` (mod 4), where `last` is the most recently granted index.
- In SHOW:
  - Every cycle, `Disp_Data`/`state` reload from the granted source's slices, so the displayed data tracks live source updates.
  - The dwell counter increments every cycle and saturates at `DWELL_CYC-1`.
- Granted source drops its request (in SHOW, any count):
  - If others are pending, re-arbitrate immediately, skipping the dropped source, and reset the dwell counter to 0.
  - Otherwise return to IDLE.
- Dwell expired (counter = `DWELL_CYC-1`) and another source requests: grant the next round-robin requester and clear the counter.
- Dwell expired and only the current source requests: keep the grant; the counter stays saturated.
- `last` updates on every new grant. On reset it is 3, so source 0 wins first.
- Dwell counter width is `$clog2(DWELL_CYC)`, unsigned, and never wraps.

## Timing
- Reset values:
  - `Src_Grant` = 4'b0000.
  - `Disp_Data` = `IDLE_DATA`.
  - `state` = `IDLE_MODE`.
  - `Busy` = 0.
  - Dwell counter = 0.
  - FSM in IDLE.
- An asserted `Reset_N` clears everything immediately, including mid-SHOW. Any in-progress dwell is lost.
- Request latency: a request sampled high at edge N yields grant, `Busy`, and the source's data/mode valid after edge N+1.
- Data latency: a change on a granted source's `Src_Data` appears on `Disp_Data` one cycle later.
- Expiry switch: counter reaches `DWELL_CYC-1` at edge N; a pending other source is granted at edge N+1. No gap cycle, no overlap; `Src_Grant` is always one-hot or zero.
- Release: request low at edge N gives a new grant or IDLE at edge N+1.
- If a release and a new request from another source occur in the same cycle, the new source is granted at the next edge.

## Configuration
- `SEG_PREEMPT_EN` defined:
  - Source 0 is high priority. When `Src_Req[0]` rises while another source is granted, source 0 is granted at the next edge regardless of dwell, and the counter clears.
  - While source 0 is granted, other sources wait for full dwell expiry as normal.
- `SEG_PREEMPT_EN` not defined: pure round-robin; source 0 has no preemption.

## Test plan
All scenarios use `DWELL_CYC`=8.
- Reset: `Reset_N`=0 → `Src_Grant`=0, `Disp_Data`=`IDLE_DATA`, `state`=`IDLE_MODE`, `Busy`=0.
- Single request: `Src_Req`=4'b0010 with data 32'h0000_0001 and mode 1 → one cycle later `Src_Grant`=4'b0010, `Disp_Data`=32'h0000_0001, `state`=1; grant held indefinitely.
- Rotation: `Src_Req`=4'b1111 held → grants 0,1,2,3,0 in order, each held exactly 8 cycles.
- Early release: source 2 drops its request 3 cycles into its grant while source 3 is pending → source 3 granted on the next edge, and it holds for a full 8 cycles.
- Mid-operation reset: pulse `Reset_N` low during SHOW → outputs return to reset values immediately. After release with all requesting, source 0 is granted first.
- With `SEG_PREEMPT_EN`: source 1 granted 2 cycles, then `Src_Req[0]` rises → `Src_Grant`=4'b0001 next edge. Without the macro, source 0 waits until source 1 finishes its 8 cycles.
